// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response plus the decode-side
// valid/ready delivery channel. master = fetch queue, slave = memory/decode side.
interface fetch_queue_if #(
  parameter int unsigned INST_W = 16,
  parameter int unsigned ADDR_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC-sequential requests, DEPTH-entry queue, redirect and halt.
// Optional FQ_BYPASS_EN: a response into an empty queue with decode ready goes straight out.
module fetch_queue #(
  parameter int unsigned       INST_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_queue_if.master     bus,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              req_q;
  logic              epoch_q;
  logic              tag_q;
  logic              err_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic resp_ok;
  logic bypass;
  logic push;
  logic pop;
  logic wr_en;
  logic overflow;
  logic start;
  logic proto_err;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(DEPTH));
    // Responses tagged with a stale epoch belong to a pre-redirect stream.
    resp_ok    = (state_q == StWait) && bus.imem_rvalid && (tag_q == epoch_q);
`ifdef FQ_BYPASS_EN
    bypass     = resp_ok && fifo_empty && bus.inst_ready && !redirect;
`else
    bypass     = 1'b0;
`endif
    push       = resp_ok && !bypass;
    pop        = !fifo_empty && bus.inst_ready;
    overflow   = push && fifo_full && !pop;
    wr_en      = push && !overflow && !redirect;
    // Only IDLE can start a request, and nothing is outstanding there.
    start      = !halt && (count_q < CNT_W'(DEPTH));
    proto_err  = (bus.imem_rvalid && (state_q != StWait)) || (bus.imem_gnt && !req_q) ||
                 overflow;
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = !fifo_empty || bypass;
  assign bus.inst       = fifo_empty ? bus.imem_rdata : inst_mem_q[rd_ptr_q];
  assign bus.inst_pc    = fifo_empty ? req_pc_q : pc_mem_q[rd_ptr_q];
  assign err            = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_q    <= 1'b0;
      epoch_q  <= 1'b0;
      tag_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (proto_err) err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StReq;
            req_q   <= 1'b1;
          end
        end
        StReq: begin
          // A grant wins over a coincident redirect: the request is outstanding.
          if (bus.imem_gnt) begin
            state_q  <= StWait;
            req_q    <= 1'b0;
            tag_q    <= epoch_q;
            req_pc_q <= pc_q;
            pc_q     <= pc_q + ADDR_W'(PC_INC);
          end else if (redirect) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
          end
        end
        StWait: begin
          if (bus.imem_rvalid) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
      if (redirect) begin
        pc_q    <= redirect_pc;
        epoch_q <= !epoch_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined processor; it is the successor to the single-cycle PC/fetch path, which has a fixed 16-bit PC and fetches directly from instruction memory every cycle.
- It issues PC-sequential requests to a variable-latency instruction memory and buffers the returned instructions in a DEPTH-entry FIFO.
- It delivers instructions to decode over a valid/ready handshake.
- It supports redirect (branch/jump) with flush of stale data, and halt.

Parameters:
- INST_W, 16, instruction width in bits
- ADDR_W, 16, PC/address width in bits
- DEPTH, 4, FIFO entries (power of two, ≥2)
- PC_INC, 2, PC increment per instruction
- RESET_PC, 0, PC loaded on reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- imem_req  out  1  request valid; held with imem_addr until granted
- imem_addr  out  ADDR_W  request address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (in order, ≥1 cycle after grant)
- imem_rdata  in  INST_W  response data
- redirect  in  1  load new PC, flush queue
- redirect_pc  in  ADDR_W  target PC
- halt  in  1  stop issuing new requests
- inst_valid  out  1  queue head valid
- inst  out  INST_W  head instruction
- inst_pc  out  ADDR_W  PC of head instruction
- inst_ready  in  1  decode accepts head this cycle
- err  out  1  protocol error, sticky until reset

Behaviour:
- Reset (rst=0, async) clears the following: pc=RESET_PC, FIFO empty, count=0, outstanding=0, epoch=0, imem_req=0, inst_valid=0, err=0. Data outputs are don't-care while invalid.
- At most one outstanding request. The FSM has three states.
  - IDLE→REQ when not halted and count+outstanding < DEPTH.
  - REQ drives imem_req=1, imem_addr=pc. On imem_gnt: pc += PC_INC (mod 2^ADDR_W, wraps silently), tag = epoch, go to WAIT.
  - WAIT→IDLE on imem_rvalid.
  - Requests may issue in IDLE→REQ on the cycle after a response, so sustained throughput is 1 instruction per 3 cycles at 1-cycle memory latency.
- Response handling: if tag==epoch, push {imem_rdata, request PC} into the FIFO. Otherwise discard silently.
- Slot reservation guarantees push never overflows. A push when full sets err.
- Dequeue: inst_valid = (count>0). Pop on inst_valid & inst_ready. Push and pop in the same cycle leave count unchanged.
- Redirect, applied on the next edge:
  - FIFO cleared, pc=redirect_pc, epoch toggles.
  - In REQ, imem_req drops and the state returns to IDLE; the ungranted request is abandoned.
  - In WAIT, the state stays WAIT and the late response is discarded via the epoch mismatch.
  - A redirect coincident with a pop or push overrides both: the FIFO ends empty.
  - A redirect coincident with imem_gnt: that grant is still counted as outstanding with the old epoch.
- Halt:
  - While halt=1, no new REQ is entered. An in-flight WAIT completes and pushes normally. A REQ already asserted stays asserted until granted.
  - The FIFO keeps draining.
  - Deasserting halt resumes fetching from the current pc.
- err sets (sticky) on either condition:
  - imem_rvalid while not in WAIT
  - imem_gnt while imem_req=0
- Reset asserted mid-transaction abandons everything immediately. Memory responses arriving after reset release with no outstanding request set err.

Optional Feature:
- FQ_BYPASS_EN defined: when the FIFO is empty, a response with matching epoch arriving while inst_ready=1 is presented combinationally on inst/inst_pc with inst_valid=1 the same cycle and is not written to the FIFO. If inst_ready=0, it is written normally.
- Not defined: every response is written to the FIFO and becomes visible no earlier than the next cycle.

Test Plan:
- Reset release, memory 1-cycle latency, inst_ready=1: addresses 0,2,4,6 requested; inst_pc sequence 0,2,4,6 with matching data; err=0.
- inst_ready=0 for 20 cycles: exactly 4 entries fetched (PCs 0–6), imem_req stays 0 afterwards. Then ready=1 drains in order and fetching resumes at PC 8.
- Redirect to 0x0100 while in WAIT for PC 4: response for PC 4 discarded; next delivered inst_pc=0x0100; FIFO contents from before the redirect never appear.
- halt=1 during WAIT for PC 6: PC 6 delivered, no further request; deassert halt → request at PC 8.
- RESET_PC=0xFFFE, ADDR_W=16: second request address is 0x0000 (wrap), no err.
- imem_rvalid pulsed in IDLE → err=1 and it stays 1 until rst=0; with FQ_BYPASS_EN, empty FIFO + ready: inst_valid is high in the same cycle as imem_rvalid.
